// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use stall, branch/jump flush and forwarding-select controller
// Shadows ID/EX..MEM/WB destination info to drive stalls, flushes and operand-mux selects.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int BR_STAGE = 1,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              br_taken,
    input  logic              jmp_taken,
    output logic              stall,
    output logic              flush_if,
    output logic [DEPTH-1:0]  flush_ex,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic              wb_byp_a,
    output logic              wb_byp_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [DEPTH-1:0] BR_MASK = DEPTH'((1 << BR_STAGE) - 1);

    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  r_wr;
    logic [DEPTH-1:0]  r_load;
    logic [REG_AW-1:0] r_dst [DEPTH];
    logic [SEL_W-1:0]  r_fwd_a;
    logic [SEL_W-1:0]  r_fwd_b;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic [DEPTH-1:0]  w_m_rs;
    logic [DEPTH-1:0]  w_m_rt;
    logic [SEL_W-1:0]  w_sel_a;
    logic [SEL_W-1:0]  w_sel_b;
    logic              w_load_use;
    logic              w_stall;
    logic              w_issue;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_m_rs[k] = r_vld[k] && r_wr[k] && (r_dst[k] == id_rs) && (id_rs != '0);
            w_m_rt[k] = r_vld[k] && r_wr[k] && (r_dst[k] == id_rt) && (id_rt != '0);
        end
    end

    // Scan oldest to youngest so the youngest matching producer ends up selected.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (w_m_rs[j]) w_sel_a = SEL_W'(j + 1);
            if (w_m_rt[j]) w_sel_b = SEL_W'(j + 1);
        end
    end

    assign w_load_use = id_valid && r_load[0] &&
                        ((w_m_rs[0] && id_use_rs) || (w_m_rt[0] && id_use_rt));
    assign w_stall    = w_load_use && !br_taken;
    assign w_issue    = id_valid && !w_stall && !br_taken;

    assign stall     = w_stall;
    assign flush_if  = br_taken || (jmp_taken && !w_stall);
    assign flush_ex  = {DEPTH{br_taken}} & BR_MASK;
    assign wb_byp_a  = w_m_rs[DEPTH-1] && !(|w_m_rs[DEPTH-2:0]);
    assign wb_byp_b  = w_m_rt[DEPTH-1] && !(|w_m_rt[DEPTH-2:0]);
    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld       <= '0;
            r_wr        <= '0;
            r_load      <= '0;
            for (int k = 0; k < DEPTH; k++) r_dst[k] <= '0;
            r_fwd_a     <= '0;
            r_fwd_b     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // A taken branch clears the pipeline registers younger than its resolve stage.
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_vld[k]  <= (br_taken && (k < BR_STAGE)) ? 1'b0 : r_vld[k-1];
                r_wr[k]   <= r_wr[k-1];
                r_load[k] <= r_load[k-1];
                r_dst[k]  <= r_dst[k-1];
            end
            r_vld[0]  <= w_issue;
            r_wr[0]   <= id_wr;
            r_load[0] <= id_load;
            r_dst[0]  <= id_dst;
            r_fwd_a   <= w_issue ? w_sel_a : '0;
            r_fwd_b   <= w_issue ? w_sel_b : '0;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if ((br_taken || jmp_taken) && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined datapath.
- Tracks in-flight register writes in an internal shift register that mirrors the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Produces the load-use stall, branch/jump flushes, registered forwarding selects for the ALU operand muxes, and saturating stall/flush performance counters.
- Sits beside the control unit. Stall and flush outputs gate the PC and the pipeline-register enables and clears.

Parameters:
- REG_AW, 5: register-address width. Register 0 never creates a hazard.
- DEPTH, 3: tracked stages beyond ID. Entry 0 = EX, entry DEPTH-1 = WB. Minimum 2.
- BR_STAGE, 1: entry index where a branch resolves (1 = MEM).
- SEL_W, 2: forwarding-select width. Must satisfy 2**SEL_W >= DEPTH.
- CNT_W, 16: performance-counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_AW  ID source register A
- id_rt  in  REG_AW  ID source register B
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_dst  in  REG_AW  ID destination register (after RegDst selection)
- id_wr  in  1  instruction writes the register file
- id_load  in  1  instruction is a load (MemRead)
- br_taken  in  1  branch taken, resolved at BR_STAGE
- jmp_taken  in  1  jump decoded in ID
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- flush_if  out  1  clear IF/ID
- flush_ex  out  DEPTH  bit k clears pipeline register k (bit 0 = ID/EX)
- fwd_a  out  SEL_W  operand A select for the instruction currently in EX
- fwd_b  out  SEL_W  operand B select for the instruction currently in EX
- wb_byp_a  out  1  ID read of rs must take WB data (same-cycle write)
- wb_byp_b  out  1  ID read of rt must take WB data (same-cycle write)
- stall_cnt  out  CNT_W  stall cycles, saturating
- flush_cnt  out  CNT_W  flush events, saturating

Behaviour:
- Entry fields: valid, dst, wr, load.
- Match(k, r): entry k valid, wr=1, dst=r, r!=0.

Reset:
- rst=1 clears all entries, fwd_a, fwd_b and both counters to 0 immediately.
- A reset mid-stall or mid-flush abandons it. The first edge after release starts from an empty pipe.

Shift, every rising edge:
- Entries k>=1 take entry k-1.
- Entry 0 takes the ID instruction when id_valid=1, stall=0 and no flush. Otherwise entry 0 becomes a bubble (valid=0).

Load-use stall (combinational):
- stall = id_valid AND entry0.load AND (Match(0,id_rs) with id_use_rs, OR Match(0,id_rt) with id_use_rt).
- Lasts exactly one cycle; the load then sits in entry 1, so the next cycle no longer matches.

Forwarding selects:
- Computed from id_rs/id_rt and registered on the edge where the ID instruction enters entry 0.
- Value = j+1, where j is the lowest index in 0..DEPTH-2 with a match (youngest wins).
- Value = 0 means register-file data.
- A bubble inserted into entry 0 registers fwd=0.

WB bypass (combinational):
- wb_byp_a = Match(DEPTH-1, id_rs) AND no lower-index match.
- wb_byp_b is the same for id_rt.

Flush:
- br_taken=1 (single-cycle pulse):
  - flush_if=1, and flush_ex bits 0..BR_STAGE-1 are set.
  - Internal entries 0..BR_STAGE-1 are cleared on that edge; the ID instruction is not inserted.
  - The branch's own entry and older entries are kept.
- jmp_taken=1 (and no br_taken): flush_if=1 only; the jump itself proceeds.
- Priority br_taken > stall > jmp_taken. A stall coincident with br_taken is suppressed.

Counters:
- stall_cnt increments on each cycle with stall=1.
- flush_cnt increments on each cycle with br_taken or jmp_taken.
- Both hold at all-ones; no wrap-around.

Latency:
- stall, flush_* and wb_byp_* are combinational, same cycle.
- fwd_a and fwd_b are valid during the cycle after issue, i.e. the instruction's EX cycle.

Test Plan:
- Reset: rst pulsed mid-run -> fwd_a=0, fwd_b=0, stall=0, counters=0 with no clock edge needed; all entries invalid.
- ALU chain: add $3 (id_dst=3, id_wr=1), then sub reading rs=3 next cycle -> fwd_a=1 during sub's EX. With one independent instruction between them -> fwd_a=2.
- Load-use: lw $5, then add with rt=5 -> stall=1 for exactly one cycle, stall_cnt=1; add enters EX with fwd_b=2.
- Register zero and priority: writer to $0 followed by a reader of $0 -> fwd=0, no stall. Two consecutive writers to $7, then a reader of $7 -> fwd_a=1 (youngest wins).
- Branch: br_taken pulsed with BR_STAGE=1 -> flush_if=1, flush_ex=3'b001, entry 0 cleared, flush_cnt+1. A load-use condition in the same cycle -> stall=0.
- Saturation and WB bypass: with CNT_W=4, force 20 stall cycles -> stall_cnt=15. A reader in ID while a matching writer is in entry 2 -> wb_byp_a=1.
